// File: rtl/spm_serial_mult_if.sv
// spm_serial_mult_if: operand and product handshake bundle for the serial-parallel multiplier.
// The master side is the producer/consumer and the slave side is the multiplier.
// The optional serial product outputs (SPM_SERIAL_OUT_EN) are plain module ports, not part of this bundle.
interface spm_serial_mult_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/spm_serial_mult.sv
// spm_serial_mult: parametrised serial-parallel multiplier built from a chain of
// WIDTH carry-save cells. x is held in parallel and y is fed in LSB-first over
// 2*WIDTH cycles. The product is assembled in a shift register and offered with
// a valid/ready handshake.
// With SIGNED=1, y is sign-extended as it is shifted. The top cell feeds its own
// previous sum back in place of a missing cell above it. This emulates the
// infinite sign-extended chain, because every cell at or above the top sees the
// same x[WIDTH-1] partial product.
// Optional feature macro: SPM_SERIAL_OUT_EN adds the p_bit/p_bit_valid serial
// product stream (LSB-first, one bit per RUN cycle).
module spm_serial_mult #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  spm_serial_mult_if.slave        bus
`ifdef SPM_SERIAL_OUT_EN
  ,
  output logic                    p_bit,
  output logic                    p_bit_valid
`endif
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   x_reg;
  logic [WIDTH-1:0]   y_sr;
  logic [WIDTH-1:0]   sum_r;
  logic [WIDTH-1:0]   carry_r;
  logic [PW-1:0]      p_sr;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH-1:0]   s_in;
  logic [WIDTH-1:0]   sum_next;
  logic [WIDTH-1:0]   carry_next;
  logic               serial_bit;
  logic               accept;
  logic               last_cycle;
  logic               y_fill;

  // Carry-save cells: cell i adds its partial product, the shifted-down sum of cell i+1 and its own saved carry.
  assign pp         = x_reg & {WIDTH{y_sr[0]}};
  assign s_in       = {(SIGNED ? sum_r[WIDTH-1] : 1'b0), sum_r[WIDTH-1:1]};
  assign sum_next   = pp ^ s_in ^ carry_r;
  assign carry_next = (pp & s_in) | (pp & carry_r) | (s_in & carry_r);
  assign serial_bit = sum_next[0];

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_cycle = (count == CNT_W'(PW - 1));
  assign y_fill     = SIGNED ? y_sr[WIDTH-1] : 1'b0;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.p         = p_sr;

`ifdef SPM_SERIAL_OUT_EN
  assign p_bit_valid = (state == RUN);
  assign p_bit       = (state == RUN) & serial_bit;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run 2*WIDTH cycles, hold the product until the consumer takes it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid)  state_next = RUN;
      RUN:  if (last_cycle)    state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then step the csa chain and collect one product bit per RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg   <= '0;
      y_sr    <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      p_sr    <= '0;
      count   <= '0;
    end else if (accept) begin
      x_reg   <= bus.x;
      y_sr    <= bus.y;
      sum_r   <= '0;
      carry_r <= '0;
      p_sr    <= '0;
      count   <= '0;
    end else if (state == RUN) begin
      y_sr    <= {y_fill, y_sr[WIDTH-1:1]};
      sum_r   <= sum_next;
      carry_r <= carry_next;
      p_sr    <= {serial_bit, p_sr[PW-1:1]};
      count   <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spm_serial_mult.sv
// tb_spm_serial_mult: directed tests for spm_serial_mult at WIDTH=8.
// One unsigned and one signed instance share the clock and reset.
// Shared drivers feed the x/y operands; in_valid and out_ready are steered to one instance by sel.
module tb_spm_serial_mult;

  logic clk;
  logic rst;

  int total;
  int bad;

  logic        sel;
  logic        in_valid_drv;
  logic [7:0]  x_drv;
  logic [7:0]  y_drv;
  logic        out_ready_drv;

  logic        cur_in_ready;
  logic        cur_out_valid;
  logic        cur_busy;
  logic [15:0] cur_p;

  spm_serial_mult_if #(.WIDTH(8)) ifu ();
  spm_serial_mult_if #(.WIDTH(8)) ifs ();

  logic pbit_u;
  logic pbv_u;
  logic pbit_s;
  logic pbv_s;

  spm_serial_mult #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk(clk),
    .rst(rst),
    .bus(ifu)
`ifdef SPM_SERIAL_OUT_EN
    ,
    .p_bit(pbit_u),
    .p_bit_valid(pbv_u)
`endif
  );

  spm_serial_mult #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(ifs)
`ifdef SPM_SERIAL_OUT_EN
    ,
    .p_bit(pbit_s),
    .p_bit_valid(pbv_s)
`endif
  );

`ifndef SPM_SERIAL_OUT_EN
  assign pbit_u = 1'b0;
  assign pbv_u  = 1'b0;
  assign pbit_s = 1'b0;
  assign pbv_s  = 1'b0;
`endif

  assign ifu.in_valid  = in_valid_drv & ~sel;
  assign ifs.in_valid  = in_valid_drv & sel;
  assign ifu.out_ready = out_ready_drv & ~sel;
  assign ifs.out_ready = out_ready_drv & sel;
  assign ifu.x = x_drv;
  assign ifu.y = y_drv;
  assign ifs.x = x_drv;
  assign ifs.y = y_drv;

  assign cur_in_ready  = sel ? ifs.in_ready  : ifu.in_ready;
  assign cur_out_valid = sel ? ifs.out_valid : ifu.out_valid;
  assign cur_busy      = sel ? ifs.busy      : ifu.busy;
  assign cur_p         = sel ? ifs.p         : ifu.p;

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial stream monitor: collects p_bit LSB-first and tracks whether the valid run is contiguous.
  logic [15:0] ser_bits;
  int          ser_count;
  bit          ser_gap;
  bit          ser_prev;
  always @(negedge clk) begin
    if (pbv_u) begin
      ser_bits  = {pbit_u, ser_bits[15:1]};
      if (!ser_prev && ser_count > 0) ser_gap = 1'b1;
      ser_count = ser_count + 1;
    end
    ser_prev = pbv_u;
  end

  // Run one operation on the selected instance.
  // lat counts edges from accept to out_valid; busy_ok records busy=1/in_ready=0 just after accept.
  task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] prod, output int lat, output bit ok, output bit busy_ok);
    int n;
    ok = 1'b1;
    lat = 0;
    prod = '0;
    @(negedge clk);
    sel = s;
    in_valid_drv = 1'b1;
    x_drv = a;
    y_drv = b;
    n = 0;
    while (!cur_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    busy_ok = cur_busy && !cur_in_ready;
    @(negedge clk);
    in_valid_drv = 1'b0;
    x_drv = ~a;
    y_drv = ~b;
    lat = 1;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      if (cur_out_valid) break;
      lat++;
    end
    if (!cur_out_valid) ok = 1'b0;
    prod = cur_p;
    @(negedge clk);
    out_ready_drv = 1'b1;
    @(negedge clk);
    out_ready_drv = 1'b0;
  endtask

  // Reset state of both instances while rst is held low.
  task automatic test_reset();
    rst = 1'b0;
    sel = 1'b0;
    in_valid_drv = 1'b0;
    out_ready_drv = 1'b0;
    x_drv = '0;
    y_drv = '0;
    #1;
    total++; if (ifu.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_u: got %b expected 1", ifu.in_ready); end
    total++; if (ifu.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid_u: got %b expected 0", ifu.out_valid); end
    total++; if (ifu.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_u: got %b expected 0", ifu.busy); end
    total++; if (ifu.p !== 16'h0000) begin bad++; $display("[TB] FAIL reset_p_u: got %h expected 0000", ifu.p); end
    total++; if (ifs.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_s: got %b expected 1", ifs.in_ready); end
    total++; if (ifs.p !== 16'h0000) begin bad++; $display("[TB] FAIL reset_p_s: got %h expected 0000", ifs.p); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Unsigned products, including the accept-to-valid latency and the handshake state just after accept.
  task automatic test_unsigned();
    logic [15:0] prod;
    int lat;
    bit ok;
    bit bo;
    do_op(1'b0, 8'd13, 8'd11, prod, lat, ok, bo);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL u_13x11_timeout: got no out_valid expected out_valid"); end
    total++; if (prod !== 16'h008F) begin bad++; $display("[TB] FAIL u_13x11: got %h expected 008f", prod); end
    total++; if (lat != 16) begin bad++; $display("[TB] FAIL u_latency: got %0d expected 16", lat); end
    total++; if (bo !== 1'b1) begin bad++; $display("[TB] FAIL u_busy_after_accept: got %b expected 1", bo); end
    do_op(1'b0, 8'd255, 8'd255, prod, lat, ok, bo);
    total++; if (prod !== 16'hFE01) begin bad++; $display("[TB] FAIL u_255x255: got %h expected fe01", prod); end
    do_op(1'b0, 8'd0, 8'd200, prod, lat, ok, bo);
    total++; if (prod !== 16'h0000) begin bad++; $display("[TB] FAIL u_0x200: got %h expected 0000", prod); end
  endtask

  // Signed products covering negative operands and the most-negative corner.
  task automatic test_signed();
    logic [15:0] prod;
    int lat;
    bit ok;
    bit bo;
    do_op(1'b1, 8'hFD, 8'h05, prod, lat, ok, bo);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL s_timeout: got no out_valid expected out_valid"); end
    total++; if (prod !== 16'hFFF1) begin bad++; $display("[TB] FAIL s_m3x5: got %h expected fff1", prod); end
    total++; if (lat != 16) begin bad++; $display("[TB] FAIL s_latency: got %0d expected 16", lat); end
    do_op(1'b1, 8'h80, 8'h80, prod, lat, ok, bo);
    total++; if (prod !== 16'h4000) begin bad++; $display("[TB] FAIL s_m128xm128: got %h expected 4000", prod); end
    do_op(1'b1, 8'h7F, 8'h80, prod, lat, ok, bo);
    total++; if (prod !== 16'hC080) begin bad++; $display("[TB] FAIL s_127xm128: got %h expected c080", prod); end
    do_op(1'b1, 8'hFF, 8'hFF, prod, lat, ok, bo);
    total++; if (prod !== 16'h0001) begin bad++; $display("[TB] FAIL s_m1xm1: got %h expected 0001", prod); end
  endtask

  // Backpressure in DONE with a new operand already offered, then that operand runs to completion.
  task automatic test_backpressure();
    int n;
    int stable_bad;
    sel = 1'b0;
    @(negedge clk);
    in_valid_drv = 1'b1;
    x_drv = 8'd6;
    y_drv = 8'd7;
    @(posedge clk);
    @(negedge clk);
    x_drv = 8'd20;
    y_drv = 8'd30;
    n = 0;
    while (!cur_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (cur_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_first_valid: got %b expected 1", cur_out_valid); end
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cur_in_ready !== 1'b0 || cur_out_valid !== 1'b1 || cur_p !== 16'd42) stable_bad++;
    end
    total++; if (stable_bad != 0) begin bad++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0 (p=%h)", stable_bad, cur_p); end
    out_ready_drv = 1'b1;
    @(negedge clk);
    out_ready_drv = 1'b0;
    total++; if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", cur_in_ready, cur_out_valid); end
    @(posedge clk);
    @(negedge clk);
    in_valid_drv = 1'b0;
    n = 0;
    while (!cur_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (cur_p !== 16'd600 || cur_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_second: got %h valid=%b expected 0258 valid=1", cur_p, cur_out_valid); end
    out_ready_drv = 1'b1;
    @(negedge clk);
    out_ready_drv = 1'b0;
  endtask

  // Reset while RUN counter is 5 aborts the operation; the next operation is unaffected.
  task automatic test_reset_mid();
    logic [15:0] prod;
    int lat;
    bit ok;
    bit bo;
    int seen;
    sel = 1'b0;
    @(negedge clk);
    in_valid_drv = 1'b1;
    x_drv = 8'd50;
    y_drv = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid_drv = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0 || cur_busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ctrl: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", cur_in_ready, cur_out_valid, cur_busy); end
    total++; if (cur_p !== 16'h0000) begin bad++; $display("[TB] FAIL rmid_p: got %h expected 0000", cur_p); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL rmid_no_valid: got %0d valid cycles expected 0", seen); end
    do_op(1'b0, 8'd7, 8'd9, prod, lat, ok, bo);
    total++; if (prod !== 16'd63) begin bad++; $display("[TB] FAIL rmid_next_op: got %h expected 003f", prod); end
  endtask

`ifdef SPM_SERIAL_OUT_EN
  // Legacy serial stream: 16 contiguous valid pulses carrying 143 LSB-first.
  task automatic test_serial();
    logic [15:0] prod;
    int lat;
    bit ok;
    bit bo;
    ser_bits = '0;
    ser_count = 0;
    ser_gap = 1'b0;
    do_op(1'b0, 8'd13, 8'd11, prod, lat, ok, bo);
    total++; if (ser_count != 16) begin bad++; $display("[TB] FAIL ser_count: got %0d expected 16", ser_count); end
    total++; if (ser_bits !== 16'h008F) begin bad++; $display("[TB] FAIL ser_bits: got %h expected 008f", ser_bits); end
    total++; if (ser_gap !== 1'b0) begin bad++; $display("[TB] FAIL ser_contiguous: got gap expected none"); end
  endtask
`endif

  // Test sequence with a global time limit as a backstop.
  initial begin
    total = 0;
    bad = 0;
    ser_bits = '0;
    ser_count = 0;
    ser_gap = 1'b0;
    ser_prev = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid();
`ifdef SPM_SERIAL_OUT_EN
    test_serial();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog that stops the run if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
